// File: rtl/lp_port_ctrl.sv
// Centronics-style printer port controller: CPU byte FIFO, timed /STROBE, BUSY/ACK handshake,
// status byte and ACK interrupt. Define LP_TIMEOUT_EN to enable the WAIT_ACK timeout.
module lp_port_ctrl #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SETUP_CYC   = 4,
  parameter int STROBE_CYC  = 8,
  parameter int HOLD_CYC    = 4,
  parameter int INIT_CYC    = 16,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              wr_data,
  input  logic              wr_ctrl,
  input  logic              rd_status,
  output logic [7:0]        status,
  output logic              irq_n,
  output logic [DATA_W-1:0] lp_data,
  output logic              lp_strobe_n,
  output logic              lp_init_n,
  input  logic              lp_busy,
  input  logic              lp_ack_n,
  input  logic              lp_perror,
  input  logic              lp_select,
  input  logic              lp_fault_n
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_B   = (HOLD_CYC > INIT_CYC) ? HOLD_CYC : INIT_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  // Synchroniser order {busy, ack_n, perror, select, fault_n}; idle printer levels on reset.
  localparam logic [4:0] SYNC_RST = 5'b01001;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (DATA_W < 4 || SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || INIT_CYC < 1 ||
      ACK_TIMEOUT < 1) begin : g_bad_param
    $error("DATA_W must be >= 4 and all cycle counts >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_WAIT_ACK
  } state_t;

  state_t                  state, state_nxt;
  logic [4:0]              sync_q1, sync_q2;
  logic                    ack_n_d;
  logic                    busy_s, ack_n_s, perror_s, select_s, fault_n_s, ack_edge;
  logic [CNT_W-1:0]        cnt;
  logic                    ack_seen, irq_en, irq_pend, start;
  logic                    init_req, flush_req, push, empty, full;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic [DATA_W-1:0]       mem [FIFO_DEPTH];

  // NOTE: clocked state uses <= everywhere so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= SYNC_RST;
      sync_q2 <= SYNC_RST;
      ack_n_d <= 1'b1;
    end else begin
      sync_q1 <= {lp_busy, lp_ack_n, lp_perror, lp_select, lp_fault_n};
      sync_q2 <= sync_q1;
      ack_n_d <= sync_q2[3];
    end
  end

  assign {busy_s, ack_n_s, perror_s, select_s, fault_n_s} = sync_q2;
  assign ack_edge  = ack_n_d & ~ack_n_s;

  assign init_req  = wr_ctrl & cpu_wdata[1];
  assign flush_req = wr_ctrl & (cpu_wdata[1] | cpu_wdata[2]);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  assign push  = wr_data && (!full || start) && !flush_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (start) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cpu_wdata;
  end

`ifdef LP_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit, timeout;
`endif

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
`ifdef LP_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!empty && !busy_s && lp_init_n && !init_req) begin
          start     = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP:  if (cnt == '0) state_nxt = ST_STROBE;
      ST_STROBE: if (cnt == '0) state_nxt = ST_HOLD;
      ST_HOLD:   if (cnt == '0) state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ack_edge || ack_seen) begin
          state_nxt = ST_IDLE;
        end
`ifdef LP_TIMEOUT_EN
        else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = ST_IDLE;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (init_req) state_nxt = ST_IDLE;
  end

  // The shared counter times the transfer phases, or the /INIT pulse while the FSM idles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lp_strobe_n <= 1'b1;
      lp_init_n   <= 1'b1;
      lp_data     <= '0;
    end else begin
      state       <= state_nxt;
      lp_strobe_n <= (state_nxt != ST_STROBE);
      if (start) lp_data <= mem[rd_ptr[AW-1:0]];
      if (init_req) begin
        cnt <= CNT_W'(INIT_CYC - 1);
      end else if (state_nxt != state) begin
        case (state_nxt)
          ST_SETUP:  cnt <= CNT_W'(SETUP_CYC - 1);
          ST_STROBE: cnt <= CNT_W'(STROBE_CYC - 1);
          ST_HOLD:   cnt <= CNT_W'(HOLD_CYC - 1);
          default:   cnt <= cnt;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (init_req)                        lp_init_n <= 1'b0;
      else if (!lp_init_n && cnt == '0)    lp_init_n <= 1'b1;
    end
  end

  // An early ACK during the strobe sequence is remembered until WAIT_ACK consumes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_seen <= 1'b0;
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      if (state == ST_IDLE || state == ST_WAIT_ACK) ack_seen <= 1'b0;
      else if (ack_edge)                             ack_seen <= 1'b1;
      if (wr_ctrl) irq_en <= cpu_wdata[0];
      if (ack_edge && irq_en) irq_pend <= 1'b1;
      else if (rd_status)     irq_pend <= 1'b0;
    end
  end

`ifdef LP_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt <= (state == ST_WAIT_ACK) ? to_cnt + 1'b1 : '0;
      if (to_hit)                       timeout <= 1'b1;
      else if (wr_ctrl && cpu_wdata[3]) timeout <= 1'b0;
    end
  end
  assign status = {irq_pend, ~fault_n_s | timeout, select_s, perror_s, busy_s,
                   state != ST_IDLE, full, empty};
`else
  assign status = {irq_pend, ~fault_n_s, select_s, perror_s, busy_s,
                   state != ST_IDLE, full, empty};
`endif

  assign irq_n = ~irq_pend;

endmodule

// File: doc/lp_port_ctrl.md
Name: lp_port_ctrl

Overview:
- Parametrised, clocked successor to the FM-7 printer/tape peripheral latch logic.
- Buffers CPU-written bytes in a FIFO and drives a Centronics-style port: data setup, timed /STROBE, hold, then BUSY/ACK handshake.
- Exposes a status byte and an ACK interrupt that is cleared by reading status.
- Sits between the main-CPU I/O decode (write/read strobes) and the external printer connector.

Parameters:
DATA_W, 8, printer data width
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
SETUP_CYC, 4, clocks data is stable before /STROBE falls (>=1)
STROBE_CYC, 8, clocks /STROBE is held low (>=1)
HOLD_CYC, 4, clocks data is held after /STROBE rises (>=1)
INIT_CYC, 16, clocks /INIT is held low after an init request
ACK_TIMEOUT, 65535, WAIT_ACK timeout in clocks (used only with LP_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_wdata  in  DATA_W  CPU write data
wr_data  in  1  1-clk strobe: push cpu_wdata into FIFO
wr_ctrl  in  1  1-clk strobe: write control; bit0 irq_en, bit1 init, bit2 flush, bit3 clr_timeout
rd_status  in  1  1-clk strobe: status read (clears irq_pend)
status  out  8  {irq_pend, fault|timeout, select, perror, busy_s, active, full, empty}
irq_n  out  1  active-low interrupt, = ~irq_pend
lp_data  out  DATA_W  printer data
lp_strobe_n  out  1  printer /STROBE
lp_init_n  out  1  printer /INIT
lp_busy  in  1  printer BUSY, async
lp_ack_n  in  1  printer /ACK, async
lp_perror  in  1  paper-end, async
lp_select  in  1  SELECT/ON, async
lp_fault_n  in  1  /ERROR, async

Behaviour:
- Reset: FIFO empty; FSM IDLE; lp_data=0, lp_strobe_n=1, lp_init_n=1, irq_pend=0 (irq_n=1), irq_en=0, timeout=0; status=8'h01 plus live input bits.
- All five printer inputs pass through 2-flop synchronisers. Reset values: busy=0, ack_n=1, perror=0, select=0, fault_n=1.
- ACK edge = synchronised ack_n 1->0, detected with a third flop.
- Status is combinational from registers. Bit order is MSB first as listed in Ports. active = FSM not IDLE.
- FIFO push on wr_data:
  - if full, the byte is dropped and state is unchanged;
  - if full and a pop occurs in the same cycle, the push is accepted.
- FIFO pop occurs on the IDLE->SETUP transition; the byte is latched to lp_data in that same edge.
- FSM:
  - IDLE: go to SETUP when !empty && !busy_s && lp_init_n==1.
  - SETUP: count SETUP_CYC clocks, then STROBE.
  - STROBE: lp_strobe_n=0 for exactly STROBE_CYC clocks, then HOLD.
  - HOLD: lp_strobe_n=1; count HOLD_CYC clocks, then WAIT_ACK.
  - WAIT_ACK: on ACK edge go to IDLE. An ACK edge seen during SETUP/STROBE/HOLD is latched and completes WAIT_ACK on its first cycle.
- One shared down-counter serves the SETUP, STROBE, HOLD and INIT phases.
- lp_data holds its last value in IDLE.
- irq_pend is set on any ACK edge while irq_en=1 and cleared on rd_status. If set and clear occur in the same cycle, set wins.
- wr_ctrl bit1 (init):
  - lp_init_n=0 for INIT_CYC clocks;
  - FIFO flushed;
  - FSM forced to IDLE, with lp_strobe_n=1 in the next clock (mid-strobe abort allowed);
  - a new init during an active init restarts the count.
- wr_ctrl bit2 (flush) empties the FIFO only; the byte already in flight completes.
- wr_data in the same cycle as init or flush: the flush wins and the byte is dropped.
- Reset asserted mid-transfer returns every output to its reset value immediately (async).

Optional Feature:
LP_TIMEOUT_EN:
- Defined:
  - a counter runs in WAIT_ACK;
  - after ACK_TIMEOUT clocks with no ACK edge, the sticky timeout flag is set, the byte is abandoned and the FSM returns to IDLE;
  - status bit6 = ~fault_s | timeout;
  - timeout is cleared only by wr_ctrl bit3 or reset.
- Undefined:
  - WAIT_ACK waits indefinitely;
  - bit6 = ~fault_s;
  - wr_ctrl bit3 is ignored.

Test Plan:
- Push 8'hA5, printer BUSY=0, ACK pulse 10 clk after strobe -> lp_data=A5 SETUP_CYC clk before strobe; strobe low exactly 8 clk; active drops after ACK edge+sync; empty=1.
- irq_en=1, ACK edge -> irq_n=0 within 3 clk; rd_status in the same cycle as a second ACK edge -> irq_n stays 0; a next lone rd_status -> irq_n=1.
- Push 5 bytes with BUSY=1 held, FIFO_DEPTH=4 -> full=1, 5th byte dropped; release BUSY -> exactly 4 bytes strobed in order.
- Init write during STROBE -> lp_strobe_n=1 next clk, lp_init_n low 16 clk, empty=1, no further strobes.
- LP_TIMEOUT_EN, ACK_TIMEOUT=100, no ACK -> status bit6=1 after 100 clk in WAIT_ACK, next byte proceeds; wr_ctrl bit3 clears bit6.
- Assert reset mid-SETUP -> lp_strobe_n=1, lp_data=0, irq_n=1, status[0]=1 without a clock edge.
